arbitro_mux4b: RTL and testbench

ARBITRO_MUX4B -- requirements
Module: arbitro_mux4b

---
 rtl/arbitro_mux4b.sv | 88 ++++++++
 tb/tb_arbitro_mux4b.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/arbitro_mux4b.sv
// Purpose : two-requester 4-bit arbiter; winner's word goes through one shared
//           2:1 mux into a registered output slot (S/Valid).
// Latency : Req seen in a free-slot cycle -> Ack same cycle -> S/Valid next edge.
// Backpr. : slot is free when empty or being drained (Ready=1); otherwise no Ack.
// Ports   : clk/rst (async active-high); ReqA/DataA, ReqB/DataB requesters;
//           AckA/AckB combinational grants; Sel mux select; S/Valid/Ready output slot.
module arbitro_mux4b #(
    parameter bit PRIO_INICIAL = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ReqA,
    input  logic [3:0] DataA,
    input  logic       ReqB,
    input  logic [3:0] DataB,
    output logic       AckA,
    output logic       AckB,
    output logic       Sel,
    output logic [3:0] S,
    output logic       Valid,
    input  logic       Ready
);

    typedef enum logic {
        OCIOSO  = 1'b0,
        ENTREGA = 1'b1
    } estado_t;

    estado_t    estado_q, estado_d;
    logic [3:0] s_q, s_d;
    logic       sel_q, sel_d;
    logic       ultimo_q, ultimo_d;   // source served by the most recent capture

    logic       libre;
    logic       captura;
    logic       grant;
    logic [3:0] mux_dat;

    always_comb begin
        libre    = (estado_q == OCIOSO) || Ready;
        // Reset gates the capture so no Ack can escape while rst is high.
        captura  = !rst && libre && (ReqA || ReqB);

        // Conflict: rotate away from the last served source. Otherwise the
        // lone requester wins (ReqB alone -> 1, ReqA alone -> 0).
        if (ReqA && ReqB) begin
            grant = ~ultimo_q;
        end else begin
            grant = ReqB;
        end

        // Sel follows the grant only on a capture and otherwise holds.
        sel_d    = captura ? grant : sel_q;
        mux_dat  = sel_d ? DataB : DataA;

        s_d      = s_q;
        estado_d = estado_q;
        ultimo_d = ultimo_q;
        if (captura) begin
            s_d      = mux_dat;
            estado_d = ENTREGA;
            ultimo_d = grant;
        end else if (estado_q == ENTREGA && Ready) begin
            estado_d = OCIOSO;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estado_q <= OCIOSO;
            s_q      <= 4'b0000;
            sel_q    <= PRIO_INICIAL;
            ultimo_q <= ~PRIO_INICIAL;
        end else begin
            estado_q <= estado_d;
            s_q      <= s_d;
            sel_q    <= sel_d;
            ultimo_q <= ultimo_d;
        end
    end

    assign AckA  = captura && !grant;
    assign AckB  = captura && grant;
    assign Sel   = sel_d;
    assign S     = s_q;
    assign Valid = (estado_q == ENTREGA);

endmodule

// File: tb/tb_arbitro_mux4b.sv
module tb_arbitro_mux4b;

    logic       clk;
    logic       rst;
    logic       ReqA, ReqB, Ready;
    logic [3:0] DataA, DataB;
    logic       AckA, AckB, Sel, Valid;
    logic [3:0] S;

    int         checks   = 0;
    int         failures = 0;
    logic [3:0] exp_q[$];

    arbitro_mux4b #(.PRIO_INICIAL(1'b0)) dut (
        .clk   (clk),
        .rst   (rst),
        .ReqA  (ReqA),
        .DataA (DataA),
        .ReqB  (ReqB),
        .DataB (DataB),
        .AckA  (AckA),
        .AckB  (AckB),
        .Sel   (Sel),
        .S     (S),
        .Valid (Valid),
        .Ready (Ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard: every delivered word (Valid && Ready) must match the oldest
    // expected word pushed by the scenario that caused its capture.
    always @(negedge clk) begin
        if (!rst) begin
            checks++;
            if (AckA && AckB) begin
                failures++;
                $display("FAIL both_acks got AckA=%0b AckB=%0b exp not both high", AckA, AckB);
            end
            if (Valid && Ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL sb_unexpected got S=%0h exp no delivery", S);
                end else begin
                    logic [3:0] e;
                    e = exp_q.pop_front();
                    if (S !== e) begin
                        failures++;
                        $display("FAIL sb_word got S=%0h exp %0h", S, e);
                    end
                end
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; ReqA = 1'b1; ReqB = 1'b1; DataA = 4'h1; DataB = 4'h2; Ready = 1'b1;
        @(negedge clk);
        checks++; if (AckA !== 1'b0 || AckB !== 1'b0) begin failures++; $display("FAIL rst_acks got %0b%0b exp 00", AckA, AckB); end
        checks++; if (Valid !== 1'b0) begin failures++; $display("FAIL rst_valid got %0b exp 0", Valid); end
        checks++; if (S !== 4'h0) begin failures++; $display("FAIL rst_s got %0h exp 0", S); end
        checks++; if (Sel !== 1'b0) begin failures++; $display("FAIL rst_sel got %0b exp 0", Sel); end
        next_cycle();
        ReqA = 1'b0; ReqB = 1'b0;
        rst = 1'b0;
    endtask

    task automatic test_rotation();
        logic [3:0] seq [4];
        seq[0] = 4'h3; seq[1] = 4'hC; seq[2] = 4'h3; seq[3] = 4'hC;
        ReqA = 1'b1; ReqB = 1'b1; DataA = 4'h3; DataB = 4'hC; Ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (AckA !== (i % 2 == 0) || AckB !== (i % 2 == 1)) begin
                failures++;
                $display("FAIL rot_ack%0d got A=%0b B=%0b exp A=%0b", i, AckA, AckB, (i % 2 == 0));
            end
            checks++; if (Sel !== (i % 2 == 1)) begin failures++; $display("FAIL rot_sel%0d got %0b exp %0b", i, Sel, (i % 2 == 1)); end
            if (i > 0) begin
                checks++; if (Valid !== 1'b1) begin failures++; $display("FAIL rot_valid%0d got %0b exp 1", i, Valid); end
            end
            exp_q.push_back(seq[i]);
            next_cycle();
            checks++; if (S !== seq[i]) begin failures++; $display("FAIL rot_s%0d got %0h exp %0h", i, S, seq[i]); end
        end
        ReqA = 1'b0; ReqB = 1'b0;
    endtask

    task automatic test_idle();
        // Last word (C) is delivered this cycle with nothing pending.
        next_cycle();
        checks++; if (Valid !== 1'b0) begin failures++; $display("FAIL idle_valid got %0b exp 0", Valid); end
        checks++; if (S !== 4'hC) begin failures++; $display("FAIL idle_s got %0h exp c", S); end
        checks++; if (Sel !== 1'b1) begin failures++; $display("FAIL idle_sel got %0b exp 1", Sel); end
    endtask

    task automatic test_single();
        ReqA = 1'b1; DataA = 4'h5; Ready = 1'b1;
        @(negedge clk);
        checks++; if (AckA !== 1'b1 || AckB !== 1'b0) begin failures++; $display("FAIL single_ack got A=%0b B=%0b exp A=1 B=0", AckA, AckB); end
        exp_q.push_back(4'h5);
        next_cycle();
        ReqA = 1'b0;
        checks++; if (S !== 4'h5 || Valid !== 1'b1) begin failures++; $display("FAIL single_out got S=%0h V=%0b exp S=5 V=1", S, Valid); end
        checks++; if (Sel !== 1'b0) begin failures++; $display("FAIL single_sel got %0b exp 0", Sel); end
        next_cycle();
    endtask

    task automatic test_hold();
        ReqA = 1'b1; DataA = 4'h9; Ready = 1'b0;
        @(negedge clk);
        exp_q.push_back(4'h9);
        next_cycle();
        ReqA = 1'b0; ReqB = 1'b1; DataB = 4'h6;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (AckB !== 1'b0) begin failures++; $display("FAIL hold_ackb%0d got %0b exp 0", i, AckB); end
            checks++; if (S !== 4'h9 || Valid !== 1'b1) begin failures++; $display("FAIL hold_s%0d got S=%0h V=%0b exp S=9 V=1", i, S, Valid); end
            next_cycle();
        end
        Ready = 1'b1;
        @(negedge clk);
        checks++; if (AckB !== 1'b1 || AckA !== 1'b0) begin failures++; $display("FAIL hold_release got A=%0b B=%0b exp A=0 B=1", AckA, AckB); end
        exp_q.push_back(4'h6);
        next_cycle();
        ReqB = 1'b0;
        checks++; if (S !== 4'h6) begin failures++; $display("FAIL hold_new_s got %0h exp 6", S); end
        next_cycle();
    endtask

    task automatic test_withdraw();
        ReqA = 1'b1; DataA = 4'h1; Ready = 1'b1;
        @(negedge clk);
        exp_q.push_back(4'h1);
        next_cycle();
        ReqA = 1'b0; ReqB = 1'b1; DataB = 4'h4; Ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++; if (AckB !== 1'b0) begin failures++; $display("FAIL wd_ackb%0d got %0b exp 0", i, AckB); end
            next_cycle();
        end
        ReqB = 1'b0; Ready = 1'b1;
        @(negedge clk);
        checks++; if (AckA !== 1'b0 || AckB !== 1'b0) begin failures++; $display("FAIL wd_noack got A=%0b B=%0b exp 00", AckA, AckB); end
        next_cycle();
        checks++; if (Valid !== 1'b0) begin failures++; $display("FAIL wd_idle got %0b exp 0", Valid); end
        // Last capture served A, so the conflict must go to B first.
        ReqA = 1'b1; ReqB = 1'b1; DataA = 4'h2; DataB = 4'hD;
        @(negedge clk);
        checks++; if (AckB !== 1'b1 || AckA !== 1'b0) begin failures++; $display("FAIL wd_conf1 got A=%0b B=%0b exp A=0 B=1", AckA, AckB); end
        exp_q.push_back(4'hD);
        next_cycle();
        checks++; if (S !== 4'hD) begin failures++; $display("FAIL wd_s1 got %0h exp d", S); end
        @(negedge clk);
        checks++; if (AckA !== 1'b1 || AckB !== 1'b0) begin failures++; $display("FAIL wd_conf2 got A=%0b B=%0b exp A=1 B=0", AckA, AckB); end
        exp_q.push_back(4'h2);
        next_cycle();
        ReqA = 1'b0; ReqB = 1'b0;
        next_cycle();
    endtask

    task automatic test_reset_mid();
        ReqA = 1'b1; DataA = 4'hA; Ready = 1'b0;
        @(negedge clk);
        exp_q.push_back(4'hA);
        next_cycle();
        ReqA = 1'b0;
        checks++; if (S !== 4'hA || Valid !== 1'b1) begin failures++; $display("FAIL rm_pre got S=%0h V=%0b exp S=a V=1", S, Valid); end
        #2;
        ReqA = 1'b1; Ready = 1'b1;
        rst = 1'b1;
        #1;
        checks++; if (Valid !== 1'b0 || S !== 4'h0) begin failures++; $display("FAIL rm_async got S=%0h V=%0b exp S=0 V=0", S, Valid); end
        checks++; if (AckA !== 1'b0 || AckB !== 1'b0) begin failures++; $display("FAIL rm_acks got A=%0b B=%0b exp 00", AckA, AckB); end
        checks++; if (Sel !== 1'b0) begin failures++; $display("FAIL rm_sel got %0b exp 0", Sel); end
        exp_q.delete();
        next_cycle();
        rst = 1'b0; ReqB = 1'b1; DataA = 4'h7; DataB = 4'h8;
        @(negedge clk);
        checks++; if (AckA !== 1'b1 || AckB !== 1'b0) begin failures++; $display("FAIL rm_first got A=%0b B=%0b exp A=1 B=0", AckA, AckB); end
        exp_q.push_back(4'h7);
        next_cycle();
        @(negedge clk);
        checks++; if (AckB !== 1'b1 || AckA !== 1'b0) begin failures++; $display("FAIL rm_second got A=%0b B=%0b exp A=0 B=1", AckA, AckB); end
        exp_q.push_back(4'h8);
        next_cycle();
        ReqA = 1'b0; ReqB = 1'b0;
        next_cycle();
        checks++; if (Valid !== 1'b0 || S !== 4'h8) begin failures++; $display("FAIL rm_end got S=%0h V=%0b exp S=8 V=0", S, Valid); end
    endtask

    initial begin
        rst = 1'b1; ReqA = 1'b0; ReqB = 1'b0; DataA = 4'h0; DataB = 4'h0; Ready = 1'b0;
        test_reset();
        test_rotation();
        test_idle();
        test_single();
        test_hold();
        test_withdraw();
        test_reset_mid();
        next_cycle();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL sb_leftover got %0d words exp 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
